// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: serial byte/halfword/word access controller for a word-addressed
// synchronous RAM. Sub-word stores are done as read-merge-write. Loads return
// the addressed lane, sign- or zero-extended. Misaligned requests are answered
// with an error and never reach the RAM.
module mem_rmw_ctrl #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [31:0]       resp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t              state_reg, state_next;
   logic                we_reg;
   logic [1:0]          size_reg;
   logic                signed_reg;
   logic [ADDR_W-1:0]   waddr_reg;
   logic [1:0]          boff_reg;
   logic [31:0]         wdata_reg;
   logic                err_reg;
   logic [31:0]         word_reg;
   logic [31:0]         rdata_reg;

   logic                accept;
   logic                dec_err;
   logic [31:0]         lane_word;
   logic [31:0]         load_ext;
   logic [31:0]         merged;

   // Address bits above the RAM window are deliberately ignored (addresses wrap).
   logic                unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

   assign accept  = req_valid && (state_reg == IDLE);
   assign dec_err = (req_size == 2'b11) ||
                    ((req_size == 2'b01) && req_addr[0]) ||
                    ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

   // Next-state decode; word stores skip the read, errors go straight to response.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (dec_err)
                  state_next = RESP;
               else if (req_we && (req_size == 2'b10))
                  state_next = WR;
               else
                  state_next = RD;
            end
         end
         RD:      state_next = CAP;
         CAP:     state_next = we_reg ? WR : RESP;
         WR:      state_next = RESP;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Latch the request on acceptance so it stays stable for the whole access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_reg     <= 1'b0;
         size_reg   <= 2'b00;
         signed_reg <= 1'b0;
         waddr_reg  <= '0;
         boff_reg   <= 2'b00;
         wdata_reg  <= '0;
         err_reg    <= 1'b0;
      end else if (accept) begin
         we_reg     <= req_we;
         size_reg   <= req_size;
         signed_reg <= req_signed;
         waddr_reg  <= req_addr[ADDR_W+1:2];
         boff_reg   <= req_addr[1:0];
         wdata_reg  <= req_wdata;
         err_reg    <= dec_err;
      end
   end

   // Lane extraction from the RAM word; halfword offsets are 0 or 2 so the same shift works.
   always_comb begin
      lane_word = mem_rdata >> {boff_reg, 3'b000};
      case (size_reg)
         2'b00:   load_ext = {{24{signed_reg & lane_word[7]}}, lane_word[7:0]};
         2'b01:   load_ext = {{16{signed_reg & lane_word[15]}}, lane_word[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   // Capture the read word for the merge, and load the response data on entry to RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_reg  <= '0;
         rdata_reg <= '0;
      end else begin
         if (state_reg == CAP)
            word_reg <= mem_rdata;
         if ((state_reg != RESP) && (state_next == RESP))
            rdata_reg <= (state_reg == CAP) ? load_ext : 32'h0;
      end
   end

   // Per-lane merge: a lane takes new store data when the access covers it.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         logic       lane_en;
         logic [7:0] lane_src;
         assign lane_en  = (size_reg == 2'b10) ||
                           ((size_reg == 2'b00) && (boff_reg == LANE)) ||
                           ((size_reg == 2'b01) && (boff_reg[1] == LANE[1]));
         assign lane_src = (size_reg == 2'b00) ? wdata_reg[7:0] :
                           (size_reg == 2'b01) ? (LANE[0] ? wdata_reg[15:8] : wdata_reg[7:0]) :
                                                 wdata_reg[8*gi +: 8];
         assign merged[8*gi +: 8] = lane_en ? lane_src : word_reg[8*gi +: 8];
      end
   endgenerate

   // All outputs decode from registered state only.
   assign req_ready  = (state_reg == IDLE);
   assign mem_re     = (state_reg == RD);
   assign mem_we     = (state_reg == WR);
   assign mem_addr   = waddr_reg;
   assign mem_wdata  = mem_we ? merged : 32'h0;
   assign resp_valid = (state_reg == RESP);
   assign resp_err   = resp_valid && err_reg;
   assign resp_rdata = rdata_reg;

endmodule

// File: doc/mem_rmw_ctrl.md
# mem_rmw_ctrl

Sequential data-memory access controller placed between the CPU load/store path and a synchronous word-addressed data RAM. It accepts one byte, halfword or word access at a time over a valid/ready handshake. Sub-word stores are done as read-modify-write: read the word, merge the new lane, write the word back. Loads return the word with the addressed lane extracted and sign- or zero-extended. Misaligned accesses are rejected with an error response and never touch memory.

## Interface
- ADDR_W, 10, word-address width driven to the RAM (byte address bits [ADDR_W+1:2])
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  CPU access request
- req_ready  out  1  controller idle, request accepted when req_valid & req_ready at clk edge
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  qualifies resp_valid: misaligned or illegal size
- resp_rdata  out  32  load result (0 for stores and errors), held until next response
- mem_addr  out  ADDR_W  RAM word address
- mem_re  out  1  RAM read strobe
- mem_we  out  1  RAM write strobe
- mem_wdata  out  32  RAM write word, 0 when mem_we low
- mem_rdata  in  32  RAM read data, valid the cycle after mem_re

## Operation
- States: IDLE, RD, CAP, WR, RESP. Request fields are latched on acceptance and are stable for the whole access.
- IDLE: req_ready=1. On accept:
  - error if size 11, halfword with addr[0]=1, or word with addr[1:0]!=0 → RESP with err.
  - word store → WR.
  - all other accesses → RD.
- RD: mem_re=1, mem_addr = addr[ADDR_W+1:2] → CAP.
- CAP: capture mem_rdata into the word register. Load → RESP. Sub-word store → WR.
- WR: mem_we=1, mem_wdata = merged word → RESP.
  - Byte merge replaces only lane addr[1:0]: lane 0 = [7:0], lane 3 = [31:24].
  - Halfword merge replaces [15:0] when addr[1]=0, [31:16] when addr[1]=1.
  - Word store writes req_wdata unchanged.
  - Bits outside the lane equal the captured word.
- RESP: resp_valid=1, resp_err per decode → IDLE. resp_rdata register loads in the same cycle as RESP is entered:
  - load: extracted lane, extended per req_signed to 32 bits.
  - store or error: 0.
- mem_re and mem_we are never high together. Each accepted access produces exactly one resp_valid pulse.
- req_valid while req_ready=0 is ignored; the requester must hold it.

## Timing
- Handshake edge = E0. Response pulse occurs in cycle:
  - error: 1 after E0.
  - word store: 2 after E0.
  - load: 3 after E0.
  - sub-word store: 4 after E0.
- req_ready is low from the cycle after E0 through the RESP cycle. It is high again in the cycle after RESP, so back-to-back throughput is one access per (latency+1) cycles.
- Strobes, mem_addr and mem_wdata are decoded from registered state only, with no combinational path from req_*.
- Reset (rst_n low, asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_re=0, mem_we=0, mem_wdata=0, mem_addr=0, latched request cleared.
- Reset asserted mid-access aborts it immediately, with no response pulse. If reset falls before the WR clock edge, no partial write occurs.
- Address bits above ADDR_W+1 are ignored, so addresses wrap within the RAM.

## Test plan
- After reset, check all outputs are at their reset values. Load word at 0x10 with RAM[4]=0xA1B2C3D4 → mem_re in cycle 1 with addr 4; resp_valid in cycle 3 with rdata 0xA1B2C3D4 and err 0.
- RAM[4]=0x11223344; store byte 0xEE at 0x12 → one read, then one write of 0x11EE3344 in cycle 3; resp in cycle 4 with rdata 0.
- RAM[4]=0x8000FF7F; signed byte load at 0x10 → 0x0000007F. Signed byte load at 0x11 → 0xFFFFFFFF. Unsigned half load at 0x12 → 0x00008000. Signed half load at 0x12 → 0xFFFF8000.
- Store half at 0x13, store word at 0x12, and size 11 each → resp_valid with err=1 in cycle 1; mem_re and mem_we never asserted. Word store 0xDEADBEEF at 0x20 → single write to addr 8 in cycle 1, no read, resp in cycle 2.
- Assert rst_n low during CAP of a byte store → no mem_we, no resp_valid, req_ready=1 immediately; RAM unchanged.
- Hold req_valid high continuously with 3 queued requests → each is accepted only when req_ready=1, and exactly 3 response pulses arrive in order.
